mac_ifm_driver: RTL and testbench

Initiator side of the MAC operand interface. Buffers 4-bit operand pairs from an upstream valid/ready stream, issues them one at a time to the MAC on `in1_IFM`/`in2_IFM`/`in_valid`, waits for the MAC's `out_valid` strobe, and returns the captured 10-bit MAC result downstream on a valid/ready stream. It sits between the feature-map sequencer and the MAC, and shares the MAC's clock and reset.

---
 rtl/mac_drv_pkg.sv | 26 ++
 rtl/mac_drv_fifo.sv | 58 +++++
 rtl/mac_ifm_driver.sv | 139 +++++++++++++
 tb/tb_mac_ifm_driver.sv | 376 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mac_drv_pkg.sv
// Shared types and widths for the MAC operand driver: FSM state encoding,
// operand/result/tag widths and the 8-bit accumulate step used by the shadow checker.
package mac_drv_pkg;

    localparam int OP_W  = 4;
    localparam int RES_W = 10;
    localparam int TAG_W = 4;
    localparam int ACC_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_HOLD
    } drv_state_e;

    // Operands are zero-extended before the multiply so the product is not truncated to OP_W.
    function automatic logic [ACC_W-1:0] mac_step(input logic [ACC_W-1:0] acc,
                                                  input logic [OP_W-1:0]  a,
                                                  input logic [OP_W-1:0]  b);
        logic [ACC_W-1:0] prod;
        prod = ACC_W'(a) * ACC_W'(b);
        return acc + prod;
    endfunction

endpackage

// File: rtl/mac_drv_fifo.sv
// Synchronous operand FIFO, DEPTH x W, with full/empty flags; DEPTH must be a power of 2
// so the pointers wrap naturally. Push while full and pop while empty are ignored.
module mac_drv_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] wdata,
    input  logic         pop,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [AW:0]   count_q, count_d;
    logic          do_push, do_pop;

    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem_q[rptr_q];

    always_comb begin
        wptr_d  = do_push ? wptr_q + AW'(1) : wptr_q;
        rptr_d  = do_pop  ? rptr_q + AW'(1) : rptr_q;
        count_d = count_q;
        if (do_push && !do_pop)
            count_d = count_q + (AW+1)'(1);
        else if (do_pop && !do_push)
            count_d = count_q - (AW+1)'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Storage is not reset; emptiness is tracked by the pointers and count alone.
    always_ff @(posedge clk) begin
        if (do_push)
            mem_q[wptr_q] <= wdata;
    end

endmodule

// File: rtl/mac_ifm_driver.sv
// Initiator side of the MAC operand interface: buffers operand pairs, issues them one at a
// time, waits for the MAC result and hands it downstream. MAC_DRV_CHECK_EN adds a shadow checker.
module mac_ifm_driver
    import mac_drv_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [OP_W-1:0]  s_a,
    input  logic [OP_W-1:0]  s_b,
    output logic [OP_W-1:0]  in1_IFM,
    output logic [OP_W-1:0]  in2_IFM,
    output logic             in_valid,
    input  logic [RES_W-1:0] mac_out,
    input  logic             mac_out_valid,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [RES_W-1:0] m_res,
    output logic [TAG_W-1:0] m_tag,
    output logic             err_timeout
`ifdef MAC_DRV_CHECK_EN
    ,
    output logic             err_mismatch
`endif
);
    localparam int TW = $clog2(TIMEOUT);

    drv_state_e        state_q;
    logic [OP_W-1:0]   in1_q, in2_q;
    logic              in_valid_q;
    logic              m_valid_q;
    logic [RES_W-1:0]  m_res_q;
    logic [TAG_W-1:0]  m_tag_q;
    logic [TAG_W-1:0]  tag_q;
    logic [TW-1:0]     timer_q;
    logic              err_timeout_q;
    logic [2*OP_W-1:0] head;
    logic              fifo_full, fifo_empty;
`ifdef MAC_DRV_CHECK_EN
    logic [ACC_W-1:0]  exp_q;
    logic              err_mismatch_q;
`endif

    mac_drv_fifo #(
        .DEPTH (DEPTH),
        .W     (2*OP_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (s_valid && !fifo_full),
        .wdata ({s_a, s_b}),
        .pop   (state_q == ST_ISSUE),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign s_ready     = !fifo_full;
    assign in1_IFM     = in1_q;
    assign in2_IFM     = in2_q;
    assign in_valid    = in_valid_q;
    assign m_valid     = m_valid_q;
    assign m_res       = m_res_q;
    assign m_tag       = m_tag_q;
    assign err_timeout = err_timeout_q;
`ifdef MAC_DRV_CHECK_EN
    assign err_mismatch = err_mismatch_q;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            in1_q         <= '0;
            in2_q         <= '0;
            in_valid_q    <= 1'b0;
            m_valid_q     <= 1'b0;
            m_res_q       <= '0;
            m_tag_q       <= '0;
            tag_q         <= '0;
            timer_q       <= '0;
            err_timeout_q <= 1'b0;
`ifdef MAC_DRV_CHECK_EN
            exp_q          <= '0;
            err_mismatch_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                // Operands are latched on entry so they are registered during the ISSUE cycle.
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        in1_q      <= head[2*OP_W-1:OP_W];
                        in2_q      <= head[OP_W-1:0];
                        in_valid_q <= 1'b1;
                        state_q    <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    in1_q      <= '0;
                    in2_q      <= '0;
                    in_valid_q <= 1'b0;
                    tag_q      <= tag_q + TAG_W'(1);
                    timer_q    <= '0;
`ifdef MAC_DRV_CHECK_EN
                    exp_q      <= mac_step(exp_q, in1_q, in2_q);
`endif
                    state_q    <= ST_WAIT;
                end
                ST_WAIT: begin
                    timer_q <= timer_q + TW'(1);
                    if (mac_out_valid) begin
                        m_res_q   <= mac_out;
                        m_tag_q   <= tag_q;
                        m_valid_q <= 1'b1;
`ifdef MAC_DRV_CHECK_EN
                        if (mac_out != {{(RES_W-ACC_W){1'b0}}, exp_q})
                            err_mismatch_q <= 1'b1;
`endif
                        state_q   <= ST_HOLD;
                    end else if (timer_q == TW'(TIMEOUT-1)) begin
                        err_timeout_q <= 1'b1;
                        state_q       <= ST_IDLE;
                    end
                end
                ST_HOLD: begin
                    if (m_ready) begin
                        m_valid_q <= 1'b0;
                        state_q   <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mac_ifm_driver.sv
// Self-checking bench for mac_ifm_driver: a MAC environment model, a transaction-level
// reference checked every cycle, directed scenarios with literal expectations, then random traffic.
`timescale 1ns/1ps
module tb_mac_ifm_driver;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 8;
    localparam int NK      = 512;
    localparam int NEVER   = 32'h7fffffff;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       s_valid = 1'b0;
    logic [3:0] s_a = '0, s_b = '0;
    logic       m_ready = 1'b0;
    logic [9:0] mac_out = '0;
    logic       mac_out_valid = 1'b0;
    logic       s_ready, in_valid, m_valid, err_timeout;
    logic [3:0] in1_IFM, in2_IFM, m_tag;
    logic [9:0] m_res;
`ifdef MAC_DRV_CHECK_EN
    logic       err_mismatch;
`endif

    mac_ifm_driver #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .s_valid(s_valid), .s_ready(s_ready), .s_a(s_a), .s_b(s_b),
        .in1_IFM(in1_IFM), .in2_IFM(in2_IFM), .in_valid(in_valid),
        .mac_out(mac_out), .mac_out_valid(mac_out_valid),
        .m_valid(m_valid), .m_ready(m_ready), .m_res(m_res), .m_tag(m_tag),
        .err_timeout(err_timeout)
`ifdef MAC_DRV_CHECK_EN
        , .err_mismatch(err_mismatch)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // Per-issue knobs for the MAC environment: drop the result, upper result bits, corrupt value.
    bit         drop_k    [NK];
    bit         corrupt_k [NK];
    logic [1:0] hi_k      [NK];

    // MAC environment state
    int         env_n = 0;
    logic [7:0] env_acc = '0;
    int         sched_cyc = -1;
    int         late_cyc = -1;
    logic [9:0] sched_val = '0;

    // Observed event logs for literal checks
    int         iss_c[$];
    logic [3:0] iss_a[$], iss_b[$];
    int         res_c[$];
    logic [9:0] res_v[$];
    logic [3:0] res_t[$];
    int         err_c = -1;
    bit         prev_mv = 1'b0;

    // Reference model state
    typedef struct { logic [3:0] a; logic [3:0] b; int pc; } pair_t;
    pair_t      mq[$];
    bit         mb_busy = 1'b0;
    bit         mb_drop = 1'b0;
    int         mb_t = 0, mb_idle = 0, mb_n = 0, mb_ok = 0;
    logic [3:0] mb_tag = '0;
    logic [7:0] mb_acc = '0;
    logic [9:0] mb_val = '0;
    int         err_from = NEVER;
`ifdef MAC_DRV_CHECK_EN
    int         mm_from = NEVER;
`endif

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d got=%0d expected=%0d", name, cyc, act, exp);
        end
    endtask

    // Cycle counter and MAC result strobe, driven just after each rising edge.
    initial forever begin
        @(posedge clk);
        cyc++;
        #1;
        if (cyc == sched_cyc) begin
            mac_out_valid = 1'b1;
            mac_out       = sched_val;
        end else if (cyc == late_cyc) begin
            mac_out_valid = 1'b1;
            mac_out       = 10'h3ff;
        end else begin
            mac_out_valid = 1'b0;
        end
    end

    // Environment, logging and reference compare on every falling edge.
    initial forever begin
        bit    e_iv, e_sr, e_mv;
        pair_t hp;
        int    n;
        logic [9:0] v;
        @(negedge clk);
        if (rst) begin
            env_n = 0; env_acc = '0; sched_cyc = -1; late_cyc = -1;
        end else if (in_valid) begin
            n = env_n;
            env_n++;
            env_acc = env_acc + 8'(in1_IFM) * 8'(in2_IFM);
            v = corrupt_k[n] ? 10'd7 : {hi_k[n], env_acc};
            if (!drop_k[n]) begin
                sched_cyc = cyc + 4;
                sched_val = v;
            end else begin
                late_cyc = cyc + 10;
            end
        end
        if (in_valid) begin
            iss_c.push_back(cyc); iss_a.push_back(in1_IFM); iss_b.push_back(in2_IFM);
        end
        if (m_valid && !prev_mv) begin
            res_c.push_back(cyc); res_v.push_back(m_res); res_t.push_back(m_tag);
        end
        if (err_timeout && err_c < 0) err_c = cyc;
        prev_mv = m_valid;

        if (rst) begin
            chk("rst_s_ready", s_ready, 1);
            chk("rst_in_valid", in_valid, 0);
            chk("rst_in1", in1_IFM, 0);
            chk("rst_in2", in2_IFM, 0);
            chk("rst_m_valid", m_valid, 0);
            chk("rst_m_res", m_res, 0);
            chk("rst_m_tag", m_tag, 0);
            chk("rst_err_timeout", err_timeout, 0);
`ifdef MAC_DRV_CHECK_EN
            chk("rst_err_mismatch", err_mismatch, 0);
            mm_from = NEVER;
`endif
            mq.delete();
            mb_busy = 1'b0; mb_idle = cyc + 1; mb_n = 0; mb_ok = 0;
            mb_tag = '0; mb_acc = '0; err_from = NEVER;
        end else begin
            e_iv = !mb_busy && mq.size() > 0 && mb_idle <= cyc - 1;
            if (e_iv) e_iv = (mq[0].pc <= cyc - 2);
            e_sr = (mq.size() < DEPTH);
            e_mv = mb_busy && !mb_drop && (cyc >= mb_t + 5);
            hp.a = '0; hp.b = '0; hp.pc = 0;
            if (e_iv) hp = mq[0];
            chk("s_ready", s_ready, e_sr);
            chk("in_valid", in_valid, e_iv);
            chk("in1_IFM", in1_IFM, hp.a);
            chk("in2_IFM", in2_IFM, hp.b);
            chk("m_valid", m_valid, e_mv);
            if (e_mv) begin
                chk("m_res", m_res, mb_val);
                chk("m_tag", m_tag, mb_tag);
            end
            chk("err_timeout", err_timeout, cyc >= err_from);
`ifdef MAC_DRV_CHECK_EN
            chk("err_mismatch", err_mismatch, cyc >= mm_from);
`endif
            if (e_iv) begin
                void'(mq.pop_front());
                mb_busy = 1'b1;
                mb_t    = cyc;
                mb_tag  = mb_tag + 4'd1;
                mb_acc  = mb_acc + 8'(hp.a) * 8'(hp.b);
                mb_drop = drop_k[mb_n];
                mb_val  = corrupt_k[mb_n] ? 10'd7 : {hi_k[mb_n], mb_acc};
                mb_n++;
                if (mb_drop && err_from == NEVER) err_from = cyc + TIMEOUT + 1;
            end else if (mb_busy) begin
                if (mb_drop) begin
                    if (cyc == mb_t + TIMEOUT) begin
                        mb_busy = 1'b0; mb_idle = cyc + 1;
                    end
                end else begin
`ifdef MAC_DRV_CHECK_EN
                    if (cyc == mb_t + 4 && mb_val != {2'b00, mb_acc} && mm_from == NEVER)
                        mm_from = cyc + 1;
`endif
                    if (cyc >= mb_t + 5 && m_ready) begin
                        mb_busy = 1'b0; mb_idle = cyc + 1; mb_ok++;
                    end
                end
            end
            if (s_valid && e_sr) mq.push_back('{a: s_a, b: s_b, pc: cyc});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; s_valid = 1'b0; m_ready = 1'b0;
        for (int i = 0; i < NK; i++) begin
            drop_k[i] = 1'b0; corrupt_k[i] = 1'b0; hi_k[i] = 2'b00;
        end
        tick(); tick();
        rst = 1'b0;
        iss_c.delete(); iss_a.delete(); iss_b.delete();
        res_c.delete(); res_v.delete(); res_t.delete();
        err_c = -1;
    endtask

    task automatic push(input logic [3:0] a, input logic [3:0] b, output int acc_c);
        bit ok = 1'b0;
        acc_c = -1;
        s_valid = 1'b1; s_a = a; s_b = b;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            ok = s_ready;
            if (ok) acc_c = cyc;
            tick();
        end
        s_valid = 1'b0;
        if (!ok) chk("push_accept", 0, 1);
    endtask

    initial begin
        int k, k2;
        bit seen;
        logic [9:0] exp_sums [5];
        exp_sums = '{10'd2, 10'd14, 10'd44, 10'd100, 10'd190};

        // Single pair (3,5)
        do_reset();
        m_ready = 1'b1;
        push(4'd3, 4'd5, k);
        repeat (12) tick();
        chk("p35_issue_cycle", iss_c.size() > 0 ? iss_c[0] : -1, k + 2);
        chk("p35_in1", iss_a.size() > 0 ? iss_a[0] : 4'hx, 3);
        chk("p35_in2", iss_b.size() > 0 ? iss_b[0] : 4'hx, 5);
        chk("p35_mvalid_cycle", res_c.size() > 0 ? res_c[0] : -1, k + 7);
        chk("p35_m_res", res_v.size() > 0 ? res_v[0] : 10'hx, 15);
        chk("p35_m_tag", res_t.size() > 0 ? res_t[0] : 4'hx, 1);
        chk("p35_err_timeout", err_timeout, 0);

        // Back-to-back (15,15) x2
        do_reset();
        m_ready = 1'b1;
        push(4'd15, 4'd15, k);
        push(4'd15, 4'd15, k2);
        repeat (25) tick();
        chk("ff_count", res_v.size(), 2);
        if (res_v.size() == 2) begin
            chk("ff_res0", res_v[0], 225);
            chk("ff_res1", res_v[1], 194);
            chk("ff_tag0", res_t[0], 1);
            chk("ff_tag1", res_t[1], 2);
        end
        if (iss_c.size() == 2) chk("ff_issue_gap", iss_c[1] - iss_c[0], 7);
        else chk("ff_issue_count", iss_c.size(), 2);

        // Downstream stall with five pairs
        do_reset();
        m_ready = 1'b0;
        push(4'd1, 4'd2, k); push(4'd3, 4'd4, k); push(4'd5, 4'd6, k);
        push(4'd7, 4'd8, k); push(4'd9, 4'd10, k);
        @(negedge clk);
        chk("stall_s_ready_low", s_ready, 0);
        repeat (12) tick();
        @(negedge clk);
        chk("stall_m_valid", m_valid, 1);
        chk("stall_m_res_held", m_res, 2);
        chk("stall_m_tag_held", m_tag, 1);
        tick();
        m_ready = 1'b1;
        repeat (50) tick();
        chk("stall_count", res_v.size(), 5);
        for (int i = 0; i < 5 && i < res_v.size(); i++) begin
            chk("stall_res", res_v[i], exp_sums[i]);
            chk("stall_tag", res_t[i], i + 1);
        end

        // Lost result and recovery
        do_reset();
        m_ready = 1'b1;
        drop_k[0] = 1'b1;
        push(4'd4, 4'd4, k);
        push(4'd2, 4'd2, k2);
        repeat (30) tick();
        chk("to_err_cycle", (iss_c.size() > 0) ? err_c - iss_c[0] : -1, TIMEOUT + 1);
        chk("to_next_issue_gap", (iss_c.size() > 1) ? iss_c[1] - iss_c[0] : -1, TIMEOUT + 2);
        chk("to_res_count", res_v.size(), 1);
        chk("to_res", res_v.size() > 0 ? res_v[0] : 10'hx, 20);
        chk("to_tag", res_t.size() > 0 ? res_t[0] : 4'hx, 2);
        chk("to_err_sticky", err_timeout, 1);

`ifdef MAC_DRV_CHECK_EN
        // Forced wrong result is flagged but still delivered
        do_reset();
        m_ready = 1'b1;
        corrupt_k[0] = 1'b1;
        push(4'd2, 4'd3, k);
        repeat (12) tick();
        chk("mm_res", res_v.size() > 0 ? res_v[0] : 10'hx, 7);
        chk("mm_flag", err_mismatch, 1);
`else
        // Upper result bits are forwarded untouched
        do_reset();
        m_ready = 1'b1;
        hi_k[0] = 2'b10;
        push(4'd3, 4'd3, k);
        repeat (12) tick();
        chk("hi_res", res_v.size() > 0 ? res_v[0] : 10'hx, 521);
        chk("hi_tag", res_t.size() > 0 ? res_t[0] : 4'hx, 1);
`endif

        // Reset while waiting for the MAC
        do_reset();
        m_ready = 1'b1;
        push(4'd6, 4'd7, k);
        push(4'd8, 4'd8, k2);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = in_valid;
            tick();
        end
        chk("rw_issue_seen", seen, 1);
        tick();
        rst = 1'b1;
        @(negedge clk);
        chk("rw_s_ready", s_ready, 1);
        chk("rw_m_valid", m_valid, 0);
        chk("rw_in_valid", in_valid, 0);
        do_reset();
        m_ready = 1'b1;
        repeat (5) tick();
        chk("rw_fifo_empty", iss_c.size(), 0);
        push(4'd1, 4'd1, k);
        repeat (12) tick();
        chk("rw_res", res_v.size() > 0 ? res_v[0] : 10'hx, 1);
        chk("rw_tag", res_t.size() > 0 ? res_t[0] : 4'hx, 1);

        // Random traffic
        do_reset();
        for (int i = 0; i < NK; i++) begin
            drop_k[i] = ($urandom_range(0, 7) == 0);
`ifdef MAC_DRV_CHECK_EN
            corrupt_k[i] = ($urandom_range(0, 15) == 0);
`else
            hi_k[i] = 2'($urandom);
`endif
        end
        for (int i = 0; i < 600; i++) begin
            s_valid = ($urandom_range(0, 9) < 6);
            s_a     = 4'($urandom);
            s_b     = 4'($urandom);
            m_ready = 1'($urandom);
            tick();
        end
        s_valid = 1'b0;
        m_ready = 1'b1;
        repeat (80) tick();
        chk("rand_drain_results", res_v.size(), mb_ok);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog cycle=%0d", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
